// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, functs, ALU operations,
// register aliases and the decoder control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_T0   = 5'd8;
    localparam logic [4:0] REG_S0   = 5'd16;
    localparam logic [4:0] REG_T8   = 5'd24;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst_rd;
        logic    alu_src_imm;
        logic    imm_zext;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch_eq;
        logic    branch_ne;
        logic    jump;
        logic    use_funct;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
        ext_imm = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit wrap-around ALU; shifts act on operand b by shamt.
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);

    // Operation select
    always_comb begin
        y = 32'h0000_0000;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'h0, ($signed(a) < $signed(b))};
            ALU_SLL: y = b << shamt;
            ALU_SRL: y = b >> shamt;
            default: y = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mips_alu_ctrl.sv
// ALU control: R-type funct decode, or pass-through of the decoder's I-type operation.
module mips_alu_ctrl
    import mips_pkg::*;
(
    input  logic       use_funct,
    input  logic [5:0] funct,
    input  alu_op_e    i_op,
    output alu_op_e    op,
    output logic       valid
);

    // valid drops for an unsupported funct so the register write is suppressed
    always_comb begin
        op    = ALU_ADD;
        valid = 1'b0;
        if (use_funct) begin
            case (funct)
                FN_ADD: begin op = ALU_ADD; valid = 1'b1; end
                FN_SUB: begin op = ALU_SUB; valid = 1'b1; end
                FN_AND: begin op = ALU_AND; valid = 1'b1; end
                FN_OR:  begin op = ALU_OR;  valid = 1'b1; end
                FN_SLT: begin op = ALU_SLT; valid = 1'b1; end
                FN_SLL: begin op = ALU_SLL; valid = 1'b1; end
                FN_SRL: begin op = ALU_SRL; valid = 1'b1; end
                default: begin op = ALU_ADD; valid = 1'b0; end
            endcase
        end else begin
            op    = i_op;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/mips_control.sv
// Main decoder: opcode to datapath control bundle; unknown opcodes produce no side effects.
module mips_control
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    // Opcode decode
    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst_rd = 1'b1;
                ctrl.use_funct  = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = ALU_ADD;
            end
            OP_ANDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_zext    = 1'b1;
                ctrl.alu_op      = ALU_AND;
            end
            OP_ORI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_zext    = 1'b1;
                ctrl.alu_op      = ALU_OR;
            end
            OP_SLTI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = ALU_SLT;
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_op      = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.alu_op      = ALU_ADD;
            end
            OP_BEQ:  ctrl.branch_eq = 1'b1;
            OP_BNE:  ctrl.branch_ne = 1'b1;
            OP_J:    ctrl.jump      = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_dmem.sv
// Data RAM: combinational read, write on the rising edge, cleared by reset.
module mips_dmem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    input  logic          we,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] mem_d [0:DEPTH-1];

    // Next RAM contents for a store
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[idx] = wdata;
        end else begin
            mem_d[idx] = mem_q[idx];
        end
    end

    // RAM storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: 32'h0000_0000};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mips_imem.sv
// Instruction ROM, word-indexed; fetches beyond the image return 0 (a nop).
module mips_imem #(
    parameter int    DEPTH    = 64,
    parameter string MEM_FILE = "instructions.txt"
) (
    input  logic [29:0] word_addr,
    output logic [31:0] instr
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] rom_mem [0:DEPTH-1];

    // Combinational fetch with out-of-range addresses reading as nop
    always_comb begin
        if (word_addr < 30'(DEPTH)) begin
            instr = rom_mem[word_addr[AW-1:0]];
        end else begin
            instr = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/mips_npc.sv
// Next-PC selection: jump, then taken branch, then sequential.
module mips_npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic        jump,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] pc_next
);

    logic [31:0] pc_plus4_s;
    logic [31:0] br_target_s;
    logic        taken_s;

    // Priority mux over the three next-PC sources
    always_comb begin
        pc_plus4_s  = pc + 32'd4;
        br_target_s = pc_plus4_s + (ext_imm(imm, 1'b0) << 2);
        taken_s     = (branch_eq && (rs_val == rt_val)) || (branch_ne && (rs_val != rt_val));
        if (jump) begin
            pc_next = {pc_plus4_s[31:28], target, 2'b00};
        end else if (taken_s) begin
            pc_next = br_target_s;
        end else begin
            pc_next = pc_plus4_s;
        end
    end

endmodule

// File: rtl/mips_pc.sv
// Program counter register; the flop is named out so it can be probed as asset_pc.out.
module mips_pc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_d,
    output logic [31:0] out
);

    // PC update, reset wins over any computed next PC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= 32'h0000_0000;
        end else begin
            out <= pc_d;
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hard-wired to zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] RegData   [0:31];
    logic [31:0] regdata_d [0:31];

    // Next array contents: at most one register replaced, $0 never written
    always_comb begin
        regdata_d = RegData;
        if (we && (wa != REG_ZERO)) begin
            regdata_d[wa] = wd;
        end else begin
            regdata_d[wa] = RegData[wa];
        end
        regdata_d[REG_ZERO] = 32'h0000_0000;
    end

    // Register array storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegData <= '{default: 32'h0000_0000};
        end else begin
            RegData <= regdata_d;
        end
    end

    assign rd1 = (ra1 == REG_ZERO) ? 32'h0000_0000 : RegData[ra1];
    assign rd2 = (ra2 == REG_ZERO) ? 32'h0000_0000 : RegData[ra2];

endmodule

// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS subset core: every instruction fetches, executes and retires in one clock.
module mips_single_cycle_top
    import mips_pkg::*;
#(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 32,
    parameter string IMEM_FILE  = "instructions.txt"
) (
    input logic clk,
    input logic rst_n
);

    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [31:0] instr_s;
    ctrl_t       ctrl_s;
    alu_op_e     alu_op_s;
    logic        alu_valid_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;
    logic [31:0] imm_ext_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_y_s;
    logic [31:0] mem_rdata_s;
    logic [31:0] wd_s;
    logic [4:0]  wa_s;
    logic        we_s;

    mips_pc asset_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_d  (pc_next_s),
        .out   (pc_s)
    );

    mips_imem #(.DEPTH(IMEM_DEPTH), .MEM_FILE(IMEM_FILE)) u_imem (
        .word_addr (pc_s[31:2]),
        .instr     (instr_s)
    );

    mips_control u_ctrl (
        .op   (instr_s[31:26]),
        .ctrl (ctrl_s)
    );

    mips_alu_ctrl u_alu_ctrl (
        .use_funct (ctrl_s.use_funct),
        .funct     (instr_s[5:0]),
        .i_op      (ctrl_s.alu_op),
        .op        (alu_op_s),
        .valid     (alu_valid_s)
    );

    mips_regfile asset_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (instr_s[25:21]),
        .ra2   (instr_s[20:16]),
        .wa    (wa_s),
        .wd    (wd_s),
        .we    (we_s),
        .rd1   (rd1_s),
        .rd2   (rd2_s)
    );

    // Operand, destination and writeback selection
    always_comb begin
        imm_ext_s = ext_imm(instr_s[15:0], ctrl_s.imm_zext);
        if (ctrl_s.alu_src_imm) begin
            alu_b_s = imm_ext_s;
        end else begin
            alu_b_s = rd2_s;
        end
        if (ctrl_s.reg_dst_rd) begin
            wa_s = instr_s[15:11];
        end else begin
            wa_s = instr_s[20:16];
        end
        if (ctrl_s.mem_to_reg) begin
            wd_s = mem_rdata_s;
        end else begin
            wd_s = alu_y_s;
        end
        we_s = ctrl_s.reg_write && alu_valid_s;
    end

    mips_alu u_alu (
        .op    (alu_op_s),
        .a     (rd1_s),
        .b     (alu_b_s),
        .shamt (instr_s[10:6]),
        .y     (alu_y_s)
    );

    // Word address wraps modulo the RAM depth by keeping only the low index bits
    mips_dmem #(.DEPTH(DMEM_DEPTH), .AW(DMEM_AW)) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (alu_y_s[DMEM_AW+1:2]),
        .wdata (rd2_s),
        .we    (ctrl_s.mem_write),
        .rdata (mem_rdata_s)
    );

    mips_npc u_npc (
        .pc        (pc_s),
        .imm       (instr_s[15:0]),
        .target    (instr_s[25:0]),
        .jump      (ctrl_s.jump),
        .branch_eq (ctrl_s.branch_eq),
        .branch_ne (ctrl_s.branch_ne),
        .rs_val    (rd1_s),
        .rt_val    (rd2_s),
        .pc_next   (pc_next_s)
    );

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Bench for mips_single_cycle_top: directed programs plus random programs, each cycle compared
// against an instruction-level reference model of PC, registers and data RAM.
module tb_mips_single_cycle_top;
    import mips_pkg::*;

    localparam logic [4:0] S1 = REG_S0 + 5'd1;
    localparam logic [4:0] S2 = REG_S0 + 5'd2;
    localparam logic [4:0] S3 = REG_S0 + 5'd3;
    localparam logic [4:0] T1 = REG_T0 + 5'd1;
    localparam logic [4:0] T2 = REG_T0 + 5'd2;
    localparam logic [4:0] T3 = REG_T0 + 5'd3;
    localparam logic [4:0] T4 = REG_T0 + 5'd4;
    localparam logic [4:0] T5 = REG_T0 + 5'd5;
    localparam logic [4:0] T6 = REG_T0 + 5'd6;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    logic [31:0] tb_rom [0:63];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_mem  [0:31];
    logic [31:0] m_pc;
    logic [31:0] prog [$];

    mips_single_cycle_top #(.IMEM_DEPTH(64), .DMEM_DEPTH(32), .IMEM_FILE("")) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 64; i++) begin
            tb_rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
            dut.u_imem.rom_mem[i] = tb_rom[i];
        end
    endtask

    // Reference: one architectural instruction step (or reset) applied to the model state
    task automatic model_edge();
        logic [31:0] ins, a, b, sx, zx, res, addr, npc;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic        wr;
        if (!rst_n) begin
            m_pc = 32'h0;
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_mem[i]  = 32'h0;
            end
            return;
        end
        ins  = (m_pc < 32'd256) ? tb_rom[m_pc[7:2]] : 32'h0;
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        fn   = ins[5:0];
        a    = m_regs[rs];
        b    = m_regs[rt];
        sx   = {{16{ins[15]}}, ins[15:0]};
        zx   = {16'h0, ins[15:0]};
        addr = a + sx;
        npc  = m_pc + 32'd4;
        wr   = 1'b0;
        dst  = rt;
        res  = 32'h0;
        case (op)
            6'h00: begin
                dst = rd;
                wr  = 1'b1;
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin res = a + sx; wr = 1'b1; end
            6'h0C: begin res = a & zx; wr = 1'b1; end
            6'h0D: begin res = a | zx; wr = 1'b1; end
            6'h0A: begin res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; wr = 1'b1; end
            6'h23: begin res = m_mem[addr[6:2]]; wr = 1'b1; end
            6'h2B: m_mem[addr[6:2]] = b;
            6'h04: if (a == b) npc = m_pc + 32'd4 + (sx << 2);
            6'h05: if (a != b) npc = m_pc + 32'd4 + (sx << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr && dst != 5'd0) m_regs[dst] = res;
        m_pc = npc;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("pc", dut.asset_pc.out, m_pc);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("reg%0d", i), dut.asset_reg.RegData[i], m_regs[i]);
            check($sformatf("mem%0d", i), dut.u_dmem.mem_q[i], m_mem[i]);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic gen_random();
        prog.delete();
        for (int i = 0; i < 64; i++) begin
            logic [4:0]  a, b, c;
            logic [15:0] imm;
            int          k, off;
            a   = 5'($urandom_range(0, 11));
            b   = 5'($urandom_range(0, 11));
            c   = 5'($urandom_range(0, 11));
            imm = 16'($urandom);
            k   = $urandom_range(0, 15);
            off = int'($urandom_range(0, 6)) - 2;
            case (k)
                0:  prog.push_back(enc_r(FN_ADD, c, a, b, 5'd0));
                1:  prog.push_back(enc_r(FN_SUB, c, a, b, 5'd0));
                2:  prog.push_back(enc_r(FN_AND, c, a, b, 5'd0));
                3:  prog.push_back(enc_r(FN_OR,  c, a, b, 5'd0));
                4:  prog.push_back(enc_r(FN_SLT, c, a, b, 5'd0));
                5:  prog.push_back(enc_r(FN_SLL, c, a, b, 5'($urandom_range(0, 31))));
                6:  prog.push_back(enc_r(FN_SRL, c, a, b, 5'($urandom_range(0, 31))));
                7:  prog.push_back(enc_i(OP_ADDI, c, a, imm));
                8:  prog.push_back(enc_i(OP_ANDI, c, a, imm));
                9:  prog.push_back(enc_i(OP_ORI,  c, a, imm));
                10: prog.push_back(enc_i(OP_SLTI, c, a, imm));
                11: prog.push_back(enc_i(OP_LW, c, a, 16'($urandom_range(0, 127))));
                12: prog.push_back(enc_i(OP_SW, b, a, 16'($urandom_range(0, 127))));
                13: prog.push_back(enc_i(($urandom_range(0, 1) == 0) ? OP_BEQ : OP_BNE, b, a, 16'(off)));
                14: prog.push_back(enc_j(26'($urandom_range(0, 70))));
                default: prog.push_back($urandom);
            endcase
        end
    endtask

    initial begin
        int rc;
        rst_n = 1'b0;

        // Arithmetic, memory, immediates and illegal encodings
        prog.delete();
        prog.push_back(enc_i(OP_ADDI, REG_S0, 5'd0, 16'd5));
        prog.push_back(enc_i(OP_ADDI, S1, 5'd0, 16'hFFFD));
        prog.push_back(enc_r(FN_ADD, S2, REG_S0, S1, 5'd0));
        prog.push_back(enc_r(FN_SUB, S3, REG_S0, S1, 5'd0));
        prog.push_back(enc_r(FN_SLT, REG_T0, S1, REG_S0, 5'd0));
        prog.push_back(enc_i(OP_ADDI, T1, 5'd0, 16'h0055));
        prog.push_back(enc_i(OP_SW, T1, 5'd0, 16'd8));
        prog.push_back(enc_i(OP_LW, T2, 5'd0, 16'd8));
        prog.push_back(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9));
        prog.push_back(enc_r(FN_SLL, T3, 5'd0, S1, 5'd4));
        prog.push_back(enc_r(FN_SRL, T4, 5'd0, S1, 5'd28));
        prog.push_back(enc_i(OP_ANDI, T5, S1, 16'hFF00));
        prog.push_back(enc_i(OP_ORI, T6, 5'd0, 16'h8001));
        prog.push_back(enc_i(OP_SLTI, REG_T8, S1, 16'hFFFE));
        prog.push_back(enc_i(6'h3F, REG_S0, REG_S0, 16'h1234));
        prog.push_back(enc_r(6'h21, REG_S0, S1, S1, 5'd0));
        load_prog();
        cycle();
        cycle();
        check("rst_pc", dut.asset_pc.out, 32'h0);
        check("rst_s0", dut.asset_reg.RegData[REG_S0], 32'h0);
        rst_n = 1'b1;
        cycle();
        check("pc_step", dut.asset_pc.out, 32'h4);
        check("first_addi", dut.asset_reg.RegData[REG_S0], 32'h5);
        rst_n = 1'b0;
        cycle();
        check("midrst_pc", dut.asset_pc.out, 32'h0);
        check("midrst_s1", dut.asset_reg.RegData[S1], 32'h0);
        check("midrst_s0", dut.asset_reg.RegData[REG_S0], 32'h0);
        rst_n = 1'b1;
        repeat (20) cycle();
        check("a_pc", dut.asset_pc.out, 32'h50);
        check("s2_add", dut.asset_reg.RegData[S2], 32'h2);
        check("s3_sub", dut.asset_reg.RegData[S3], 32'h8);
        check("t0_slt", dut.asset_reg.RegData[REG_T0], 32'h1);
        check("t2_lw", dut.asset_reg.RegData[T2], 32'h55);
        check("mem2_sw", dut.u_dmem.mem_q[2], 32'h55);
        check("zero_reg", dut.asset_reg.RegData[0], 32'h0);
        check("t3_sll", dut.asset_reg.RegData[T3], 32'hFFFF_FFD0);
        check("t4_srl", dut.asset_reg.RegData[T4], 32'h0000_000F);
        check("t5_andi", dut.asset_reg.RegData[T5], 32'h0000_FF00);
        check("t6_ori", dut.asset_reg.RegData[T6], 32'h0000_8001);
        check("t8_slti", dut.asset_reg.RegData[REG_T8], 32'h1);
        check("s0_kept", dut.asset_reg.RegData[REG_S0], 32'h5);

        // Branches, jumps and running off the end of the ROM
        rst_n = 1'b0;
        prog.delete();
        prog.push_back(enc_i(OP_ADDI, REG_S0, 5'd0, 16'd7));
        prog.push_back(enc_i(OP_ADDI, S1, 5'd0, 16'd7));
        prog.push_back(enc_j(26'd4));
        prog.push_back(enc_j(26'h40));
        prog.push_back(enc_i(OP_BEQ, S1, REG_S0, 16'd2));
        prog.push_back(enc_i(OP_ADDI, T1, 5'd0, 16'd1));
        prog.push_back(enc_i(OP_ADDI, T1, 5'd0, 16'd2));
        prog.push_back(enc_i(OP_BNE, S1, REG_S0, 16'd3));
        prog.push_back(enc_j(26'd3));
        load_prog();
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        check("j_fwd", dut.asset_pc.out, 32'h10);
        cycle();
        check("beq_taken", dut.asset_pc.out, 32'h1C);
        cycle();
        check("bne_not", dut.asset_pc.out, 32'h20);
        cycle();
        check("j_back", dut.asset_pc.out, 32'h0C);
        cycle();
        check("j_far", dut.asset_pc.out, 32'h100);
        repeat (6) cycle();
        check("nop_pc", dut.asset_pc.out, 32'h118);
        check("nop_s0", dut.asset_reg.RegData[REG_S0], 32'h7);
        check("skip_t1", dut.asset_reg.RegData[T1], 32'h0);

        // Random programs, the first one with a reset pulse part-way through
        for (int p = 0; p < 3; p++) begin
            rst_n = 1'b0;
            gen_random();
            load_prog();
            cycle();
            cycle();
            rst_n = 1'b1;
            rc = $urandom_range(20, 60);
            for (int c = 0; c < 150; c++) begin
                rst_n = (p == 0 && c == rc) ? 1'b0 : 1'b1;
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
